// File: rtl/mem_copy_engine.sv
// Memory copy/fill initiator: moves aligned 32-bit words from src to dst, or writes a
// constant word over dst, one bus access per cycle on the single-port data memory.
module mem_copy_engine #(
    parameter logic [15:0] MEM_ADDR = 16'h1000,
    parameter int          LEN_W    = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    input  logic             fill_en,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [1:0]       mem_size,
    output logic             mem_we,
    output logic             mem_re
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      fill_value_q, fill_value_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] words_done_q, words_done_d;
    logic             fill_en_q, fill_en_d;
    logic             error_q, error_d;

    // Request validation: both ends of each region must sit inside the MEM_ADDR window.
    logic [31:0] last_ofs, dst_last, src_last;
    logic        len_zero, align_bad, dst_bad, src_bad, req_error;

    always_comb begin
        len_zero  = (len_words == '0);
        last_ofs  = (32'(len_words) - 32'd1) << 2;
        dst_last  = dst_addr + last_ofs;
        src_last  = src_addr + last_ofs;
        align_bad = (dst_addr[1:0] != 2'b00) || (!fill_en && (src_addr[1:0] != 2'b00));
        dst_bad   = (dst_addr[31:16] != MEM_ADDR) || (!len_zero && (dst_last[31:16] != MEM_ADDR));
        src_bad   = !fill_en && ((src_addr[31:16] != MEM_ADDR) ||
                                 (!len_zero && (src_last[31:16] != MEM_ADDR)));
        req_error = align_bad || dst_bad || src_bad;
    end

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path
        // through the case statement can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        buf_d        = buf_q;
        fill_value_d = fill_value_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        fill_en_d    = fill_en_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d    = src_addr;
                    dst_ptr_d    = dst_addr;
                    remaining_d  = len_words;
                    fill_en_d    = fill_en;
                    fill_value_d = fill_value;
                    words_done_d = '0;
                    error_d      = req_error;
                    if (req_error || len_zero) state_d = DONE;
                    else if (fill_en)          state_d = WR;
                    else                       state_d = RD;
                end
            end
            RD: begin
                buf_d     = mem_rdata;
                src_ptr_d = src_ptr_q + 32'd4;
                state_d   = WR;
            end
            WR: begin
                dst_ptr_d    = dst_ptr_q + 32'd4;
                words_done_d = words_done_q + LEN_W'(1);
                remaining_d  = remaining_q - LEN_W'(1);
                if (remaining_q == LEN_W'(1)) state_d = DONE;
                else if (fill_en_q)           state_d = WR;
                else                          state_d = RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_size  = 2'b00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            RD: begin
                mem_addr = src_ptr_q;
                mem_size = 2'b11;
                mem_re   = 1'b1;
            end
            WR: begin
                mem_addr  = dst_ptr_q;
                mem_size  = 2'b11;
                mem_wdata = fill_en_q ? fill_value_q : buf_q;
                // The write in flight when reset arrives must not commit.
                mem_we    = !reset;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q == RD) || (state_q == WR);
    assign done       = (state_q == DONE);
    assign error      = error_q;
    assign words_done = words_done_q;

    always_ff @(posedge clock) begin
        // NOTE: datapath registers are reset too (not just the FSM) so every output and
        // pointer has a known value straight out of reset; there is no memory array here.
        if (reset) begin
            state_q      <= IDLE;
            src_ptr_q    <= 32'd0;
            dst_ptr_q    <= 32'd0;
            buf_q        <= 32'd0;
            fill_value_q <= 32'd0;
            remaining_q  <= '0;
            words_done_q <= '0;
            fill_en_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            buf_q        <= buf_d;
            fill_value_q <= fill_value_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            fill_en_q    <= fill_en_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a word-level reference model predicts bus accesses,
// completion latency and final memory contents; a negedge monitor compares them.
module tb_mem_copy_engine;
    localparam int          LEN_W    = 11;
    localparam logic [15:0] MEM_ADDR = 16'h1000;

    logic             clock = 1'b0;
    logic             reset, start, fill_en;
    logic [31:0]      src_addr, dst_addr, fill_value;
    logic [LEN_W-1:0] len_words;
    logic             busy, done, error;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [1:0]       mem_size;
    logic             mem_we, mem_re;

    mem_copy_engine #(.MEM_ADDR(MEM_ADDR), .LEN_W(LEN_W)) dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .fill_en(fill_en), .fill_value(fill_value),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_size(mem_size), .mem_we(mem_we), .mem_re(mem_re)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus-side memory: read data latched on negedge, writes commit on posedge.
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] bus_get(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    always @(negedge clock) if (mem_re) mem_rdata <= bus_get(mem_addr);
    always @(posedge clock) if (mem_we) bus_mem[mem_addr] = mem_wdata;

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        bus_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Scoreboard queues
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int t0; int lat; logic err; logic [LEN_W-1:0] wd; } dn_t;
    logic [31:0] rd_q [$];
    wr_t         wr_q [$];
    dn_t         dn_q [$];

    always @(negedge clock) begin
        if (busy === 1'b0) check("bus_quiet_when_idle", 32'({mem_re, mem_we}), 32'd0);
        if (mem_re === 1'b1) begin
            check("rd_no_we", 32'(mem_we), 32'd0);
            check("rd_size", 32'(mem_size), 32'd3);
            check("rd_expected", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) check("rd_addr", mem_addr, rd_q.pop_front());
        end
        if (mem_we === 1'b1) begin
            check("wr_no_re", 32'(mem_re), 32'd0);
            check("wr_size", 32'(mem_size), 32'd3);
            check("wr_expected", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
                wr_t w;
                w = wr_q.pop_front();
                check("wr_addr", mem_addr, w.addr);
                check("wr_data", mem_wdata, w.data);
            end
        end
        if (done === 1'b1) begin
            check("done_expected", 32'(dn_q.size() > 0), 32'd1);
            if (dn_q.size() > 0) begin
                dn_t d;
                d = dn_q.pop_front();
                check("done_latency", 32'(cyc - d.t0 + 1), 32'(d.lat));
                check("done_error", 32'(error), 32'(d.err));
                check("done_words", 32'(words_done), 32'(d.wd));
                check("done_not_busy", 32'(busy), 32'd0);
            end
            done_cnt++;
        end
    end

    // Reference rule: a request is rejected if misaligned or if any word it would touch
    // lies outside the MEM_ADDR window.
    function automatic logic model_err(input logic [31:0] src, input logic [31:0] dst,
                                       input int len, input logic fill);
        logic [31:0] a;
        logic        bad;
        bad = (dst[1:0] != 2'b00) || (dst[31:16] != MEM_ADDR);
        if (!fill) bad = bad || (src[1:0] != 2'b00) || (src[31:16] != MEM_ADDR);
        for (int i = 0; i < len; i++) begin
            a = dst + 32'(4 * i);
            if (a[31:16] != MEM_ADDR) bad = 1'b1;
            if (!fill) begin
                a = src + 32'(4 * i);
                if (a[31:16] != MEM_ADDR) bad = 1'b1;
            end
        end
        return bad;
    endfunction

    task automatic scramble_inputs();
        src_addr   = $urandom;
        dst_addr   = $urandom;
        len_words  = LEN_W'($urandom_range(0, 2047));
        fill_en    = 1'($urandom_range(0, 1));
        fill_value = $urandom;
        start      = 1'($urandom_range(0, 1));
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input logic fill, input logic [31:0] fv, input bit scramble);
        logic        err;
        logic [31:0] v;
        int          target;
        dn_t         d;
        wr_t         w;
        err = model_err(src, dst, len, fill);
        if (!err) begin
            for (int i = 0; i < len; i++) begin
                if (!fill) rd_q.push_back(src + 32'(4 * i));
                v = fill ? fv : ref_get(src + 32'(4 * i));
                ref_mem[dst + 32'(4 * i)] = v;
                w.addr = dst + 32'(4 * i);
                w.data = v;
                wr_q.push_back(w);
            end
        end
        target = done_cnt + 1;
        @(posedge clock); #1;
        src_addr   = src;
        dst_addr   = dst;
        len_words  = LEN_W'(len);
        fill_en    = fill;
        fill_value = fv;
        start      = 1'b1;
        d.t0  = cyc + 1;
        d.lat = (err || len == 0) ? 1 : (fill ? len + 1 : 2 * len + 1);
        d.err = err;
        d.wd  = err ? '0 : LEN_W'(len);
        dn_q.push_back(d);
        for (int k = 0; k < 200 && done_cnt < target; k++) begin
            @(posedge clock); #1;
            if (scramble && done_cnt < target) scramble_inputs();
            else start = 1'b0;
        end
        start = 1'b0;
        check("done_seen", 32'(done_cnt >= target), 32'd1);
        check("reads_drained", 32'(rd_q.size()), 32'd0);
        check("writes_drained", 32'(wr_q.size()), 32'd0);
        check("error_hold", 32'(error), 32'(err));
        check("idle_after_done", 32'(busy), 32'd0);
        for (int i = 0; i <= len; i++)
            check("mem_contents", bus_get(dst + 32'(4 * i)), ref_get(dst + 32'(4 * i)));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words_done"}, 32'(words_done), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_size"}, 32'(mem_size), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, d, fv;
        logic        fill;
        int          len, t0, start_done;
        dn_t         dummy;
        wr_t         w;

        reset = 1'b1; start = 1'b0; fill_en = 1'b0;
        src_addr = 32'd0; dst_addr = 32'd0; len_words = '0; fill_value = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;

        // Directed copy
        poke(32'h1000_0000, 32'h1111_1111);
        poke(32'h1000_0004, 32'h2222_2222);
        poke(32'h1000_0008, 32'h3333_3333);
        poke(32'h1000_000C, 32'h4444_4444);
        run_xfer(32'h1000_0000, 32'h1000_0100, 4, 1'b0, 32'd0, 1'b1);
        check("copy_word3", bus_get(32'h1000_010C), 32'h4444_4444);

        // Directed fill with guard word beyond the end
        poke(32'h1000_020C, 32'hADAD_ADAD);
        run_xfer(32'h0, 32'h1000_0200, 3, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check("fill_guard", bus_get(32'h1000_020C), 32'hADAD_ADAD);

        // Rejected requests and zero length
        run_xfer(32'h1000_0000, 32'h1000_0102, 1, 1'b0, 32'd0, 1'b0);
        run_xfer(32'h2000_0000, 32'h1000_0300, 2, 1'b0, 32'd0, 1'b0);
        run_xfer(32'h0, 32'h1000_FFFC, 2, 1'b1, 32'h5555_5555, 1'b0);
        run_xfer(32'h1000_0000, 32'h1000_0400, 0, 1'b0, 32'd0, 1'b1);

        // Overlapping copy replicates the first word
        poke(32'h1000_0000, 32'hAAAA_0001);
        poke(32'h1000_0004, 32'hBBBB_0002);
        run_xfer(32'h1000_0000, 32'h1000_0004, 2, 1'b0, 32'd0, 1'b0);
        check("overlap_w1", bus_get(32'h1000_0004), 32'hAAAA_0001);
        check("overlap_w2", bus_get(32'h1000_0008), 32'hAAAA_0001);

        // Reset during the write of word 2 of 4: only word 1 lands
        rd_q.push_back(32'h1000_0100);
        rd_q.push_back(32'h1000_0104);
        w.addr = 32'h1000_0500;
        w.data = ref_get(32'h1000_0100);
        wr_q.push_back(w);
        ref_mem[32'h1000_0500] = w.data;
        poke(32'h1000_0504, 32'h7777_7777);
        start_done = done_cnt;
        @(posedge clock); #1;
        src_addr = 32'h1000_0100; dst_addr = 32'h1000_0500;
        len_words = LEN_W'(4); fill_en = 1'b0; start = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 50 && cyc < t0 + 3; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_reset_vals("midreset");
        @(posedge clock); #1;
        check("midreset_no_done", 32'(done_cnt), 32'(start_done));
        check("midreset_reads", 32'(rd_q.size()), 32'd0);
        check("midreset_writes", 32'(wr_q.size()), 32'd0);
        check("midreset_word1", bus_get(32'h1000_0500), ref_get(32'h1000_0100));
        check("midreset_word2", bus_get(32'h1000_0504), 32'h7777_7777);
        run_xfer(32'h1000_0100, 32'h1000_0500, 4, 1'b0, 32'd0, 1'b0);

        // Randomized traffic in a small window so regions overlap often
        for (int i = 0; i < 256; i++) poke(32'h1000_0000 + 32'(4 * i), $urandom);
        for (int n = 0; n < 24; n++) begin
            fill = ($urandom_range(0, 2) == 0);
            len  = $urandom_range(0, 8);
            s    = 32'h1000_0000 + 32'(4 * $urandom_range(0, 63));
            d    = 32'h1000_0000 + 32'(4 * $urandom_range(0, 63));
            fv   = $urandom;
            case ($urandom_range(0, 7))
                0: begin d[1:0] = 2'($urandom_range(1, 3)); if (len == 0) len = 1; end
                1: begin s = 32'h2000_0000 | s;             if (len == 0) len = 1; end
                2: begin d = 32'h1000_FFF8;                 len = $urandom_range(3, 6); end
                3: begin s[1:0] = 2'($urandom_range(1, 3)); if (len == 0) len = 1; end
                default: ;
            endcase
            run_xfer(s, d, len, fill, fv, (n % 2) == 0);
        end

        dummy.t0 = 0;
        check("final_done_queue", 32'(dn_q.size()), 32'(dummy.t0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
